serial_adder: RTL and testbench

Parametrised bit-serial adder, the sequential successor to the single-bit full adder: one full-adder cell plus a carry flip-flop processes a WIDTH-bit operand pair LSB-first, one bit per clock. A start/busy/done handshake lets a controller launch an add and collect the registered sum, carry-out and signed-overflow flag. Optional subtract mode is compiled in by macro.

---
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus carry flop, LSB-first.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one result per WIDTH+1 cycles.
// Backpressure: start is accepted only in IDLE or DONE and ignored (not queued) while busy.
// Optional macro SERIAL_ADDER_SUB_EN compiles in subtract mode (A - B via ~B and carry-in 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 bits produced so far; the MSB is merged in on the final cycle.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             bit_s;
  logic             maj_s;
  logic             last_s;
  logic [WIDTH-1:0] res_ext;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1; Cin is overridden when sub is set.
  assign b_load = sub ? ~B : B;
  assign c_load = sub ? 1'b1 : Cin;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign b_load     = B;
  assign c_load     = Cin;
`endif

  // Full-adder cell on the current LSBs.
  assign bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign maj_s   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign last_s  = (cnt_q == CW'(WIDTH - 1));
  assign res_ext = {bit_s, res_q};

  // Next-state and datapath: load on accept, shift one bit per RUN cycle, publish on the last.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = res_ext[WIDTH-1:1];
        carry_d = maj_s;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_s) begin
          // On the MSB cycle carry_q is the carry into the MSB, so overflow needs no extra flop.
          sum_d   = res_ext;
          cout_d  = maj_s;
          ovf_d   = carry_q ^ maj_s;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: an 8-bit and a 2-bit instance share clock and reset.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
// Subtract expectations follow SERIAL_ADDER_SUB_EN when it is defined for the build.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start2, cin2, sub2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .Cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .Ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .A(a2), .B(b2), .Cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .Sum(sum2), .Cout(cout2), .Ovf(ovf2)
  );

  // Launch one 8-bit operation and wait for done; reports latency and busy cycle count.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic s,
                        output logic [7:0] sum, output logic co, output logic ov,
                        output int lat, output int busy_n, output bit timeout);
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = cin; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; busy_n = 0; timeout = 1'b1;
    if (busy8) busy_n++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) begin
        timeout = 1'b0;
        break;
      end
      if (busy8) busy_n++;
    end
    sum = sum8; co = cout8; ov = ovf8;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({busy8, done8} !== 2'b00) begin fails++; $display("FAIL reset_ctl8: got %b expected 00", {busy8, done8}); end
    tests++; if ({sum8, cout8, ovf8} !== 10'h000) begin fails++; $display("FAIL reset_out8: got %h expected 000", {sum8, cout8, ovf8}); end
    tests++; if ({busy2, done2, sum2, cout2, ovf2} !== 6'b0) begin fails++; $display("FAIL reset_all2: got %b expected 000000", {busy2, done2, sum2, cout2, ovf2}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co, ov; int lat, bn; bit to;
    do_op8(8'h0F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bn, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL basic_timeout: no done within 20 cycles"); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    tests++; if (bn !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 8", bn); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b expected 0", busy8); end
    tests++; if (s !== 8'h10) begin fails++; $display("FAIL basic_sum: got %h expected 10", s); end
    tests++; if ({co, ov} !== 2'b00) begin fails++; $display("FAIL basic_cout_ovf: got %b expected 00", {co, ov}); end
  endtask

  task automatic test_carry_ovf();
    logic [7:0] s; logic co, ov; int lat, bn; bit to;
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bn, to);
    tests++; if ({to, s, co, ov} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin fails++; $display("FAIL wrap_ff_01: got to=%b sum=%h co=%b ov=%b expected to=0 sum=00 co=1 ov=0", to, s, co, ov); end
    do_op8(8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bn, to);
    tests++; if ({to, s, co, ov} !== {1'b0, 8'h80, 1'b0, 1'b1}) begin fails++; $display("FAIL ovf_7f_01: got to=%b sum=%h co=%b ov=%b expected to=0 sum=80 co=0 ov=1", to, s, co, ov); end
    do_op8(8'h00, 8'h00, 1'b1, 1'b0, s, co, ov, lat, bn, to);
    tests++; if ({to, s, co, ov} !== {1'b0, 8'h01, 1'b0, 1'b0}) begin fails++; $display("FAIL cin_only: got to=%b sum=%h co=%b ov=%b expected to=0 sum=01 co=0 ov=0", to, s, co, ov); end
  endtask

  // All 32 {A,B,Cin} on the 2-bit instance, each next start issued during DONE.
  task automatic test_back_to_back();
    int cyc, last_done, sa, sb, tot;
    logic [4:0] v;
    logic [2:0] full;
    logic exp_ov;
    bit got;
    cyc = 0; last_done = 0;
    @(posedge clk); #1;
    a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    cyc++; start2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v = i[4:0];
      full = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b00, v[0]};
      sa = v[4] ? int'(v[4:3]) - 4 : int'(v[4:3]);
      sb = v[2] ? int'(v[2:1]) - 4 : int'(v[2:1]);
      tot = sa + sb + int'(v[0]);
      exp_ov = (tot > 1) || (tot < -2);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        cyc++;
        if (done2) begin
          got = 1'b1;
          break;
        end
      end
      tests++;
      if (!got) begin
        fails++; $display("FAIL b2b_timeout op %0d: no done within 10 cycles", i);
        break;
      end
      if ({cout2, sum2, ovf2} !== {full, exp_ov}) begin
        fails++; $display("FAIL b2b_result op %0d: got co=%b sum=%b ov=%b expected co=%b sum=%b ov=%b", i, cout2, sum2, ovf2, full[2], full[1:0], exp_ov);
      end
      if (i > 0) begin
        tests++;
        if (cyc - last_done !== 3) begin fails++; $display("FAIL b2b_spacing op %0d: got %0d cycles expected 3", i, cyc - last_done); end
      end
      last_done = cyc;
      if (i < 31) begin
        v = 5'(i + 1);
        a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0]; start2 = 1'b1;
        @(posedge clk); #1;
        cyc++; start2 = 1'b0;
        tests++;
        if ({busy2, done2} !== 2'b10) begin fails++; $display("FAIL b2b_accept op %0d: got busy,done=%b expected 10", i + 1, {busy2, done2}); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit got;
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 3; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) begin got = 1'b1; break; end
    end
    tests++; if ({got, lat} !== {1'b1, 32'd8}) begin fails++; $display("FAIL ignore_latency: got done=%b lat=%0d expected done=1 lat=8", got, lat); end
    tests++; if ({sum8, cout8, ovf8} !== {8'h46, 1'b0, 1'b0}) begin fails++; $display("FAIL ignore_result: got sum=%h co=%b ov=%b expected sum=46 co=0 ov=0", sum8, cout8, ovf8); end
    @(posedge clk); #1;
    tests++; if ({busy8, done8, sum8} !== {2'b00, 8'h46}) begin fails++; $display("FAIL ignore_not_queued: got busy=%b done=%b sum=%h expected busy=0 done=0 sum=46", busy8, done8, sum8); end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin fails++; $display("FAIL midrun_reset_outputs: got busy=%b done=%b sum=%h co=%b ov=%b expected all 0", busy8, done8, sum8, cout8, ovf8); end
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrun_no_done: got activity=%b expected 0", seen); end
  endtask

  task automatic test_reset_with_start();
    @(posedge clk); #1;
    a8 = 8'h33; b8 = 8'h44; start8 = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_wins_busy: got %b expected 0", busy8); end
    reset = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    tests++; if ({busy8, done8} !== 2'b00) begin fails++; $display("FAIL reset_wins_idle: got busy,done=%b expected 00", {busy8, done8}); end
  endtask

  task automatic test_subtract();
    logic [7:0] s; logic co, ov; int lat, bn; bit to;
    logic [7:0] e1, e2; logic c1, c2, o1, o2;
`ifdef SERIAL_ADDER_SUB_EN
    e1 = 8'hFE; c1 = 1'b0; o1 = 1'b0;
    e2 = 8'h7F; c2 = 1'b1; o2 = 1'b1;
`else
    e1 = 8'h0C; c1 = 1'b0; o1 = 1'b0;
    e2 = 8'h81; c2 = 1'b0; o2 = 1'b0;
`endif
    do_op8(8'h05, 8'h07, 1'b0, 1'b1, s, co, ov, lat, bn, to);
    tests++; if ({to, s, co, ov} !== {1'b0, e1, c1, o1}) begin fails++; $display("FAIL sub_05_07: got to=%b sum=%h co=%b ov=%b expected to=0 sum=%h co=%b ov=%b", to, s, co, ov, e1, c1, o1); end
    do_op8(8'h80, 8'h01, 1'b0, 1'b1, s, co, ov, lat, bn, to);
    tests++; if ({to, s, co, ov} !== {1'b0, e2, c2, o2}) begin fails++; $display("FAIL sub_80_01: got to=%b sum=%h co=%b ov=%b expected to=0 sum=%h co=%b ov=%b", to, s, co, ov, e2, c2, o2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_reset_with_start();
    test_subtract();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
